// File: rtl/dep_issue_scheduler.sv
// Dependency-aware issue scheduler: one dependency mask per instruction-buffer slot,
// round-robin pick among woken slots into a registered issue slot.
// Latency: a slot allocated with an empty mask in cycle N shows issue_valid in N+2.
// A done in cycle N wakes a consumer whose issue_valid rises in N+2.
// Backpressure: issue_valid && !issue_ready freezes issue_idx; selection resumes on the handshake.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   alloc_valid/idx/dep   write a new instruction and its producer mask into a FREE slot
//   issue_valid/idx/ready registered issue handshake toward the execute units
//   done_valid/idx        execution completion; frees the slot and clears its mask column
//   busy                  registered per-slot "not FREE" vector
//   alloc_err, done_err   one-cycle pulses flagging an ignored alloc / done
// Optional: define SCHED_STATS_EN to add stat_issued / stat_stall 32-bit wrapping counters.
module dep_issue_scheduler #(
  parameter int BS    = 16,
  parameter int IDX_W = $clog2(BS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic [BS-1:0]    alloc_dep,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_idx,
  input  logic             issue_ready,
  input  logic             done_valid,
  input  logic [IDX_W-1:0] done_idx,
  output logic [BS-1:0]    busy,
`ifdef SCHED_STATS_EN
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_stall,
`endif
  output logic             alloc_err,
  output logic             done_err
);

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_SEL  = 2'd2;
  localparam logic [1:0] S_EXEC = 2'd3;

  logic [BS-1:0][1:0]    state_q, state_d;
  logic [BS-1:0][BS-1:0] mask_q, mask_d;
  logic                  issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]      issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BS-1:0]         busy_q, busy_d;
  logic                  alloc_err_q, alloc_err_d;
  logic                  done_err_q, done_err_d;

  logic [BS-1:0]         ready;
  logic [BS-1:0]         busy_after_done;
  logic [BS-1:0]         self_bit;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand;
  logic                  handshake;

  assign handshake = issue_valid_q && issue_ready;

  // Wakeup looks only at registered state, so a same-cycle done never shortcuts the pick.
  always_comb begin
    ready = '0;
    for (int k = 0; k < BS; k++) begin
      ready[k] = (state_q[k] == S_PEND) && (mask_q[k] == '0);
    end
  end

  // Round-robin: first ready slot at or after rr_ptr, wrapping mod BS.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < BS; i++) begin
      cand = rr_ptr_q + IDX_W'(i);
      if (!pick_found && ready[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Same-cycle ordering: done, then handshake, then selection, then alloc.
  always_comb begin
    state_d         = state_q;
    mask_d          = mask_q;
    issue_valid_d   = issue_valid_q;
    issue_idx_d     = issue_idx_q;
    rr_ptr_d        = rr_ptr_q;
    alloc_err_d     = 1'b0;
    done_err_d      = 1'b0;
    busy_after_done = '0;
    self_bit        = '0;
    busy_d          = '0;

    if (done_valid) begin
      if (state_q[done_idx] == S_EXEC) begin
        state_d[done_idx] = S_FREE;
        for (int j = 0; j < BS; j++) begin
          mask_d[j][done_idx] = 1'b0;
        end
      end else begin
        done_err_d = 1'b1;
      end
    end

    for (int k = 0; k < BS; k++) begin
      busy_after_done[k] = (state_d[k] != S_FREE);
    end

    if (handshake) begin
      state_d[issue_idx_q] = S_EXEC;
    end

    if (!issue_valid_q || issue_ready) begin
      issue_valid_d = pick_found;
      if (pick_found) begin
        issue_idx_d       = pick_idx;
        state_d[pick_idx] = S_SEL;
        rr_ptr_d          = pick_idx + IDX_W'(1);
      end
    end

    // Masking with busy_after_done drops producers already FREE, including one
    // completing in this very cycle, so no wakeup can be missed.
    if (alloc_valid) begin
      if (busy_after_done[alloc_idx]) begin
        alloc_err_d = 1'b1;
      end else begin
        self_bit[alloc_idx] = 1'b1;
        state_d[alloc_idx]  = S_PEND;
        mask_d[alloc_idx]   = alloc_dep & busy_after_done & ~self_bit;
      end
    end

    for (int k = 0; k < BS; k++) begin
      busy_d[k] = (state_d[k] != S_FREE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= '0;
      mask_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      rr_ptr_q      <= '0;
      busy_q        <= '0;
      alloc_err_q   <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      busy_q        <= busy_d;
      alloc_err_q   <= alloc_err_d;
      done_err_q    <= done_err_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_idx   = issue_idx_q;
  assign busy        = busy_q;
  assign alloc_err   = alloc_err_q;
  assign done_err    = done_err_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_issued_q;
  logic [31:0] stat_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (handshake) begin
        stat_issued_q <= stat_issued_q + 32'd1;
      end
      if (issue_valid_q && !issue_ready) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_dep_issue_scheduler.sv
module tb_dep_issue_scheduler;

  localparam int BS    = 16;
  localparam int IDX_W = 4;
  localparam int FREE = 0, PEND = 1, SEL = 2, EXEC = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid;
  logic [IDX_W-1:0] alloc_idx;
  logic [BS-1:0]    alloc_dep;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_ready;
  logic             done_valid;
  logic [IDX_W-1:0] done_idx;
  logic [BS-1:0]    busy;
  logic             alloc_err;
  logic             done_err;
`ifdef SCHED_STATS_EN
  logic [31:0]      stat_issued;
  logic [31:0]      stat_stall;
`endif

  dep_issue_scheduler #(.BS(BS)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_idx   (alloc_idx),
    .alloc_dep   (alloc_dep),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .issue_ready (issue_ready),
    .done_valid  (done_valid),
    .done_idx    (done_idx),
    .busy        (busy),
`ifdef SCHED_STATS_EN
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
`endif
    .alloc_err   (alloc_err),
    .done_err    (done_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: slot lifecycle and masks as plain arrays.
  int            m_st[BS],   n_st[BS];
  logic [BS-1:0] m_mask[BS], n_mask[BS];
  logic          m_iv, n_iv;
  int            m_idx, n_idx, m_rr, n_rr;
  logic          m_aerr, n_aerr, m_derr, n_derr;
  logic [31:0]   m_issued, n_issued, m_stall, n_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < BS; k++) begin
      m_st[k]   = FREE;
      m_mask[k] = '0;
    end
    m_iv = 1'b0; m_idx = 0; m_rr = 0;
    m_aerr = 1'b0; m_derr = 1'b0;
    m_issued = '0; m_stall = '0;
  endtask

  task automatic model_next();
    logic [BS-1:0] occupied;
    logic [BS-1:0] self;
    n_st = m_st; n_mask = m_mask;
    n_iv = m_iv; n_idx = m_idx; n_rr = m_rr;
    n_aerr = 1'b0; n_derr = 1'b0;
    n_issued = m_issued; n_stall = m_stall;
    if (done_valid) begin
      if (m_st[done_idx] == EXEC) begin
        n_st[done_idx] = FREE;
        for (int j = 0; j < BS; j++) n_mask[j][done_idx] = 1'b0;
      end else begin
        n_derr = 1'b1;
      end
    end
    for (int k = 0; k < BS; k++) occupied[k] = (n_st[k] != FREE);
    if (m_iv && issue_ready) begin
      n_st[m_idx] = EXEC;
      n_issued = m_issued + 1;
    end
    if (m_iv && !issue_ready) n_stall = m_stall + 1;
    if (!m_iv || issue_ready) begin
      n_iv = 1'b0;
      for (int off = 0; off < BS; off++) begin
        int k;
        k = (m_rr + off) % BS;
        if (!n_iv && m_st[k] == PEND && m_mask[k] == '0) begin
          n_iv = 1'b1; n_idx = k; n_st[k] = SEL; n_rr = (k + 1) % BS;
        end
      end
    end
    if (alloc_valid) begin
      if (occupied[alloc_idx]) begin
        n_aerr = 1'b1;
      end else begin
        self = '0;
        self[alloc_idx] = 1'b1;
        n_st[alloc_idx]   = PEND;
        n_mask[alloc_idx] = alloc_dep & occupied & ~self;
      end
    end
  endtask

  task automatic compare_all();
    logic [BS-1:0] exp_busy;
    for (int k = 0; k < BS; k++) exp_busy[k] = (m_st[k] != FREE);
    check("busy", busy, exp_busy);
    check("issue_valid", issue_valid, m_iv);
    if (m_iv) check("issue_idx", issue_idx, m_idx);
    check("alloc_err", alloc_err, m_aerr);
    check("done_err", done_err, m_derr);
`ifdef SCHED_STATS_EN
    check("stat_issued", stat_issued, m_issued);
    check("stat_stall", stat_stall, m_stall);
`endif
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_st = n_st; m_mask = n_mask; m_iv = n_iv; m_idx = n_idx; m_rr = n_rr;
    m_aerr = n_aerr; m_derr = n_derr; m_issued = n_issued; m_stall = n_stall;
    compare_all();
  endtask

  task automatic clear_inputs();
    alloc_valid = 1'b0; alloc_idx = '0; alloc_dep = '0;
    done_valid = 1'b0; done_idx = '0; issue_ready = 1'b0;
  endtask

  // Asserted mid-cycle so the checks see the asynchronous clear.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_busy", busy, '0);
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_issue_idx", issue_idx, '0);
    check("rst_alloc_err", alloc_err, 1'b0);
    check("rst_done_err", done_err, 1'b0);
`ifdef SCHED_STATS_EN
    check("rst_stat_issued", stat_issued, '0);
    check("rst_stat_stall", stat_stall, '0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic alloc(input int idx, input logic [BS-1:0] dep);
    alloc_valid = 1'b1; alloc_idx = IDX_W'(idx); alloc_dep = dep;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    do_reset();

    // 1: empty-mask alloc issues two cycles later, done frees the slot
    issue_ready = 1'b1;
    alloc(3, '0); step(); alloc_valid = 1'b0;
    check("t1_busy3", busy[3], 1'b1);
    check("t1_iv_early", issue_valid, 1'b0);
    step();
    check("t1_iv", issue_valid, 1'b1);
    check("t1_idx", issue_idx, 4'd3);
    step();
    done_valid = 1'b1; done_idx = 4'd3; step(); done_valid = 1'b0;
    check("t1_busy3_free", busy[3], 1'b0);

    // 2: consumer of slot 0 waits for its done
    do_reset();
    issue_ready = 1'b1;
    alloc(0, '0); step();
    alloc(1, 16'h0001); step(); alloc_valid = 1'b0;
    check("t2_idx0", issue_idx, 4'd0);
    for (int i = 0; i < 4; i++) step();
    check("t2_waiting", issue_valid, 1'b0);
    done_valid = 1'b1; done_idx = 4'd0; step(); done_valid = 1'b0;
    check("t2_not_yet", issue_valid, 1'b0);
    step();
    check("t2_iv1", issue_valid, 1'b1);
    check("t2_idx1", issue_idx, 4'd1);

    // 3: stall holds issue_idx, then round-robin drain
    do_reset();
    alloc(2, '0); step();
    alloc(5, '0); step();
    alloc(9, '0); step(); alloc_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold", issue_idx, 4'd2);
    end
    issue_ready = 1'b1;
    step(); check("t3_rr5", issue_idx, 4'd5);
    step(); check("t3_rr9", issue_idx, 4'd9);
    step(); check("t3_drained", issue_valid, 1'b0);

    // 4: same-cycle done and re-alloc of slot 4
    do_reset();
    issue_ready = 1'b1;
    alloc(4, '0); step(); alloc_valid = 1'b0;
    step(); step();
    alloc(5, 16'h0010); step();
    alloc(4, 16'h0030); done_valid = 1'b1; done_idx = 4'd4; step();
    alloc_valid = 1'b0; done_valid = 1'b0;
    check("t4_no_aerr", alloc_err, 1'b0);
    check("t4_no_derr", done_err, 1'b0);
    check("t4_busy4", busy[4], 1'b1);
    step(); check("t4_idx5", issue_idx, 4'd5);
    step(); step(); check("t4_4_waits", issue_valid, 1'b0);
    done_valid = 1'b1; done_idx = 4'd5; step(); done_valid = 1'b0;
    step();
    check("t4_iv4", issue_valid, 1'b1);
    check("t4_idx4", issue_idx, 4'd4);

    // 5: error pulses
    do_reset();
    alloc(1, '0); step();
    alloc(2, '0); step();
    alloc(2, 16'h0002); step(); alloc_valid = 1'b0;
    check("t5_aerr", alloc_err, 1'b1);
    step(); check("t5_aerr_pulse", alloc_err, 1'b0);
    issue_ready = 1'b1; step(); issue_ready = 1'b0;
    check("t5_mask_kept", issue_idx, 4'd2);
    done_valid = 1'b1; done_idx = 4'd10; step();
    check("t5_derr_free", done_err, 1'b1);
    done_idx = 4'd2; step(); done_valid = 1'b0;
    check("t5_derr_sel", done_err, 1'b1);
    step(); check("t5_derr_pulse", done_err, 1'b0);

    // 6: async reset while slots are in flight
    do_reset();
    issue_ready = 1'b1;
    alloc(6, '0); step();
    alloc(7, '0); step();
    alloc(8, '0); step();
    check("t6_busy_pre", busy, 16'h01C0);
    do_reset();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int execq[$];
      clear_inputs();
      issue_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) == 0) begin
        alloc_valid = 1'b1;
        alloc_idx = IDX_W'($urandom_range(BS - 1));
        alloc_dep = BS'($urandom) & BS'($urandom);
      end
      for (int k = 0; k < BS; k++) if (m_st[k] == EXEC) execq.push_back(k);
      if (execq.size() > 0 && $urandom_range(2) == 0) begin
        done_valid = 1'b1;
        done_idx = IDX_W'(execq[$urandom_range(execq.size() - 1)]);
      end else if ($urandom_range(15) == 0) begin
        done_valid = 1'b1;
        done_idx = IDX_W'($urandom_range(BS - 1));
      end
      step();
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
